pit_bus_sequencer: RTL and testbench

Host-side bus master that sits directly upstream of the 8254 timer chip model. It turns single-cycle host requests into correctly timed 8254 bus cycles on CS, RD, WR, A1/A0 and D[7:0]. Supported requests are control-word writes, count loads, and count/status reads. 16-bit operations run automatically as an LSB-then-MSB pair of bus cycles, matching 8254 RW=11 access.

---
 rtl/pit_bus_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_pit_bus_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pit_bus_sequencer.sv
// Host-side bus master that turns single-cycle requests into timed 8254 bus cycles.
// Optional 2-entry request FIFO in front of the FSM is enabled by defining PIT_SEQ_CMD_FIFO_EN.
module pit_bus_sequencer #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        a0,
    output logic        a1,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        byte_q, byte_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic [1:0]  a_q, a_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic        busy_q, busy_d;

    logic        start;
    logic [1:0]  start_op, start_addr;
    logic [15:0] start_wdata;
    logic        advance, is_wr, active;

`ifdef PIT_SEQ_CMD_FIFO_EN
    logic [19:0] fifo_q [2];
    logic [19:0] fifo_d [2];
    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        push;

    assign req_ready = (count_q != 2'd2);
    assign push      = req_valid && req_ready;
    assign start     = (state_q == ST_IDLE) && (count_q != 2'd0);
    assign {start_op, start_addr, start_wdata} = fifo_q[rd_ptr_q];
    assign busy      = busy_q || (count_q != 2'd0);

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {req_op, req_addr, req_wdata};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (start) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, start};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    assign req_ready   = (state_q == ST_IDLE);
    assign start       = req_valid && req_ready;
    assign start_op    = req_op;
    assign start_addr  = req_addr;
    assign start_wdata = req_wdata;
    assign busy        = busy_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byte_d      = byte_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        advance     = (cnt_q == 4'd0);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETUP;
                    op_d       = start_op;
                    addr_d     = start_addr;
                    wdata_d    = start_wdata;
                    byte_d     = 1'b0;
                    rsp_data_d = '0;
                end
            end
            ST_SETUP:  if (advance) state_d = ST_STROBE;
            ST_STROBE: begin
                if (advance) begin
                    state_d = ST_HOLD;
                    if (op_q[0]) begin
                        if (byte_q) rsp_data_d[15:8] = d_in;
                        else        rsp_data_d[7:0]  = d_in;
                    end
                end
            end
            ST_HOLD:   if (advance) state_d = ST_RECOVER;
            ST_RECOVER: begin
                if (advance) begin
                    if (op_q[1] && !byte_q) begin
                        byte_d  = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every state change reloads the dwell counter, including RECOVER back to SETUP.
        if (state_d != state_q) begin
            case (state_d)
                ST_SETUP:   cnt_d = SETUP_LD;
                ST_STROBE:  cnt_d = STROBE_LD;
                ST_HOLD:    cnt_d = HOLD_LD;
                ST_RECOVER: cnt_d = RECOVER_LD;
                default:    cnt_d = 4'd0;
            endcase
        end else if (!advance) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Pin values are derived from the next state so they appear registered on state entry.
    always_comb begin
        is_wr   = !op_d[0];
        active  = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d  = !active;
        wr_n_d  = !((state_d == ST_STROBE) && is_wr);
        rd_n_d  = !((state_d == ST_STROBE) && !is_wr);
        d_oe_d  = active && is_wr;
        d_out_d = d_out_q;
        a_d     = a_q;
        busy_d  = (state_d != ST_IDLE);
        if (state_d == ST_SETUP) begin
            a_d = addr_d;
            if (is_wr) d_out_d = byte_d ? wdata_d[15:8] : wdata_d[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            op_q        <= 2'd0;
            addr_q      <= 2'd0;
            wdata_q     <= 16'd0;
            byte_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a_q         <= 2'd0;
            d_out_q     <= 8'd0;
            d_oe_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byte_q      <= byte_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            a_q         <= a_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign cs_n      = cs_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign a1        = a_q[1];
    assign a0        = a_q[0];
    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;

endmodule

// File: tb/tb_pit_bus_sequencer.sv
// Self-checking bench for pit_bus_sequencer: scoreboard of expected responses plus bus-trace checks.
// A second instance with STROBE_CYC=3 covers the lengthened-strobe read.
module tb_pit_bus_sequencer;

`ifdef PIT_SEQ_CMD_FIFO_EN
    localparam int FIFO_LAT = 1;
`else
    localparam int FIFO_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [1:0]  req_addr = 2'd0;
    logic [15:0] req_wdata = 16'd0;
    logic [7:0]  d_in = 8'd0;
    logic        req_ready, rsp_valid, busy, cs_n, rd_n, wr_n, a0, a1, d_oe;
    logic [15:0] rsp_data;
    logic [7:0]  d_out;

    logic        req3_valid = 1'b0;
    logic [1:0]  req3_op = 2'd0;
    logic [1:0]  req3_addr = 2'd0;
    logic [15:0] req3_wdata = 16'd0;
    logic [7:0]  d_in3 = 8'hA5;
    logic        req3_ready, rsp3_valid, busy3, cs3_n, rd3_n, wr3_n, a30, a31, d3_oe;
    logic [15:0] rsp3_data;
    logic [7:0]  d3_out;

    pit_bus_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0), .a1(a1),
        .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
    );

    pit_bus_sequencer #(.STROBE_CYC(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req3_valid), .req_ready(req3_ready),
        .req_op(req3_op), .req_addr(req3_addr), .req_wdata(req3_wdata),
        .rsp_valid(rsp3_valid), .rsp_data(rsp3_data), .busy(busy3),
        .cs_n(cs3_n), .rd_n(rd3_n), .wr_n(wr3_n), .a0(a30), .a1(a31),
        .d_out(d3_out), .d_oe(d3_oe), .d_in(d_in3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [15:0] expQ[$];
    int          acceptCyc;
    logic [31:0] csVec, wrVec, rdVec, oeVec, rvVec, busyVec;
    logic [7:0]  doutS [32];
    logic [1:0]  addrS [32];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pops one expectation per completion pulse and watches the bus invariants each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("bus_invariant",
                        {31'd0, (!rd_n && !wr_n) || (d_oe && (!rd_n || cs_n))}, 32'd0);
            if (rsp_valid) begin
                checkOutput("rsp_expected", {31'd0, expQ.size() != 0}, 32'd1);
                if (expQ.size() != 0) checkOutput("rsp_data", rsp_data, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expData);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        expQ.push_back(expData);
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic traceOp(input int n, input logic [7:0] lo, input logic [7:0] hi, input int split);
        csVec = '0; wrVec = '0; rdVec = '0; oeVec = '0; rvVec = '0; busyVec = '0;
        repeat (FIFO_LAT) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            csVec[k]   = cs_n;
            wrVec[k]   = wr_n;
            rdVec[k]   = rd_n;
            oeVec[k]   = d_oe;
            rvVec[k]   = rsp_valid;
            busyVec[k] = busy;
            doutS[k]   = d_out;
            addrS[k]   = {a1, a0};
            d_in       = (k + 1 < split) ? lo : hi;
        end
    endtask

    initial begin
        int a1c, a2c, a3c, lowCnt, lat;
        logic seen;
        logic [15:0] data3;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_pins", {23'd0, cs_n, rd_n, wr_n, a1, a0, d_oe, rsp_valid, busy, req_ready},
                    32'h1C1);
        checkOutput("reset_dout", d_out, 32'h0);
        checkOutput("reset_rsp_data", rsp_data, 32'h0);
        rst_n = 1'b1;

        applyStimulus(2'b00, 2'b11, 16'h0059, 16'h0000);
        traceOp(8, 8'h00, 8'h00, 99);
        checkOutput("wr8_cs_n", csVec, 32'hF0);
        checkOutput("wr8_wr_n", wrVec, 32'hF9);
        checkOutput("wr8_rd_n", rdVec, 32'hFF);
        checkOutput("wr8_d_oe", oeVec, 32'h0F);
        checkOutput("wr8_rsp_valid", rvVec, 32'h20);
        checkOutput("wr8_busy", busyVec, 32'h1F);
        checkOutput("wr8_d_out", doutS[1], 32'h59);
        checkOutput("wr8_addr", addrS[1], 32'h3);

        applyStimulus(2'b10, 2'b01, 16'h0010, 16'h0000);
        traceOp(16, 8'h00, 8'h00, 99);
        checkOutput("wr16_cs_n", csVec, 32'hFE10);
        checkOutput("wr16_wr_n", wrVec, 32'hFF39);
        checkOutput("wr16_d_oe", oeVec, 32'h01EF);
        checkOutput("wr16_rsp_valid", rvVec, 32'h0400);
        checkOutput("wr16_lsb", doutS[1], 32'h10);
        checkOutput("wr16_msb", doutS[6], 32'h00);
        checkOutput("wr16_addr", addrS[6], 32'h1);

        applyStimulus(2'b11, 2'b00, 16'hFFFF, 16'h1234);
        traceOp(16, 8'h34, 8'h12, 6);
        checkOutput("rd16_rd_n", rdVec, 32'hFF39);
        checkOutput("rd16_wr_n", wrVec, 32'hFFFF);
        checkOutput("rd16_d_oe", oeVec, 32'h0);
        checkOutput("rd16_rsp_valid", rvVec, 32'h0400);

        // Reset lands on the edge ending the second write-strobe cycle.
        applyStimulus(2'b00, 2'b00, 16'h00AA, 16'h0000);
        repeat (FIFO_LAT + 3) @(negedge clk);
        checkOutput("rst_mid_strobe_pre", {31'd0, wr_n}, 32'd0);
        rst_n = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("rst_mid_pins", {28'd0, wr_n, cs_n, d_oe, rsp_valid}, 32'hC);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("rst_mid_idle", {30'd0, busy, req_ready}, 32'h1);
        checkOutput("rst_mid_rsp_data", rsp_data, 32'h0);
        applyStimulus(2'b00, 2'b00, 16'h0005, 16'h0000);
        traceOp(8, 8'h00, 8'h00, 99);
        checkOutput("post_rst_wr8_rsp_valid", rvVec, 32'h20);
        checkOutput("post_rst_wr8_wr_n", wrVec, 32'hF9);

        applyStimulus(2'b00, 2'b11, 16'h0012, 16'h0000);
        a1c = acceptCyc;
        applyStimulus(2'b00, 2'b00, 16'h0005, 16'h0000);
        a2c = acceptCyc;
        checkOutput("b2b_accept_gap", a2c - a1c, (FIFO_LAT != 0) ? 32'd1 : 32'd6);
`ifdef PIT_SEQ_CMD_FIFO_EN
        applyStimulus(2'b01, 2'b01, 16'h0000, 16'h00C3);
        a3c = acceptCyc;
        checkOutput("fifo_third_gap", a3c - a2c, 32'd1);
`else
        a3c = 0;
`endif
        d_in = 8'hC3;

        @(negedge clk);
        checkOutput("s3_ready", {31'd0, req3_ready}, 32'd1);
        req3_valid = 1'b1;
        req3_op    = 2'b01;
        req3_addr  = 2'b10;
        @(posedge clk);
        #1;
        req3_valid = 1'b0;
        lowCnt = 0; lat = 0; seen = 1'b0; data3 = 16'h0;
        for (int k = 1; k <= 24 && !seen; k++) begin
            @(negedge clk);
            if (!rd3_n) lowCnt++;
            if (rsp3_valid) begin
                seen  = 1'b1;
                lat   = k - 1;
                data3 = rsp3_data;
            end
        end
        checkOutput("s3_rsp_seen", {31'd0, seen}, 32'd1);
        checkOutput("s3_latency", lat, 6 + FIFO_LAT);
        checkOutput("s3_rd_n_low", lowCnt, 32'd3);
        checkOutput("s3_rsp_data", data3, 32'h00A5);

        for (int k = 0; k < 60 && expQ.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
